// File: rtl/cp0_regs.sv
// MIPS CP0 register subset: BadVAddr, Status, Cause, EPC, with MFC0 bypass and exception/ERET sequencing.
// Define CP0_TIMER_EN to build the Count/Compare timer; without it Count and Compare read 0.
module cp0_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic [5:0]  hw_int,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  output logic [31:0] epc,
  output logic        int_req
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  logic [31:0] r_badvaddr;
  logic [31:0] r_epc;
  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [4:0]  r_exccode;
  logic [1:0]  r_ip_sw;
  logic [5:0]  r_ip_hw;

  logic        w_wr_status;
  logic        w_wr_cause;
  logic        w_wr_epc;
  logic        w_byp;
  logic        w_ti;
  logic [31:0] w_count_rd;
  logic [31:0] w_compare_rd;
  logic [31:0] w_status_q;
  logic [31:0] w_status_wr;
  logic [31:0] w_cause_q;
  logic [31:0] w_cause_wr;

  assign w_wr_status = we && (waddr == REG_STATUS);
  assign w_wr_cause  = we && (waddr == REG_CAUSE);
  assign w_wr_epc    = we && (waddr == REG_EPC);
  assign w_byp       = we && (waddr == raddr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_badvaddr <= '0;
      r_epc      <= '0;
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_exccode  <= '0;
      r_ip_sw    <= '0;
      r_ip_hw    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every branch sees pre-edge register values.
      r_ip_hw <= {hw_int[5] | w_ti, hw_int[4:0]};
      if (w_wr_status) begin
        r_im <= wdata[15:8];
        r_ie <= wdata[0];
      end
      if (w_wr_cause) r_ip_sw <= wdata[9:8];
      // Exception owns EXL/EPC/BD/ExcCode, ERET owns EXL; MTC0 only lands on fields neither claims.
      if (exc_valid) begin
        r_exccode <= exc_code;
        r_exl     <= 1'b1;
        if (!r_exl) begin
          r_epc <= exc_bd ? exc_pc - 32'd4 : exc_pc;
          r_bd  <= exc_bd;
        end
        if (exc_code == 5'd4 || exc_code == 5'd5) r_badvaddr <= exc_badvaddr;
      end else if (eret) begin
        r_exl <= 1'b0;
        if (w_wr_epc) r_epc <= wdata;
      end else begin
        if (w_wr_status) r_exl <= wdata[1];
        if (w_wr_epc)    r_epc <= wdata;
      end
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_toggle;
  logic        r_ti;
  logic        w_wr_count;
  logic        w_wr_compare;

  assign w_wr_count   = we && (waddr == REG_COUNT);
  assign w_wr_compare = we && (waddr == REG_COMPARE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_compare <= '0;
      r_toggle  <= 1'b0;
      r_ti      <= 1'b0;
    end else begin
      if (w_wr_count) begin
        r_count  <= wdata;
        r_toggle <= 1'b0;
      end else begin
        r_toggle <= ~r_toggle;
        if (r_toggle) r_count <= r_count + 32'd1;
      end
      if (w_wr_compare) r_compare <= wdata;
      // A Compare write acknowledges the timer and beats a same-cycle match.
      if (w_wr_compare)                r_ti <= 1'b0;
      else if (r_count == r_compare)   r_ti <= 1'b1;
    end
  end

  assign w_ti         = r_ti;
  assign w_count_rd   = w_byp ? wdata : r_count;
  assign w_compare_rd = w_byp ? wdata : r_compare;
`else
  assign w_ti         = 1'b0;
  assign w_count_rd   = '0;
  assign w_compare_rd = '0;
`endif

  assign w_status_q  = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
  assign w_status_wr = {9'b0, 1'b1, 6'b0, wdata[15:8], 6'b0, wdata[1], wdata[0]};
  assign w_cause_q   = {r_bd, w_ti, 14'b0, r_ip_hw, r_ip_sw, 1'b0, r_exccode, 2'b0};
  assign w_cause_wr  = {r_bd, w_ti, 14'b0, r_ip_hw, wdata[9:8], 1'b0, r_exccode, 2'b0};

  always_comb begin
    // NOTE: default assigned first so the partial case cannot infer a latch.
    rdata = '0;
    case (raddr)
      REG_BADVADDR: rdata = r_badvaddr;
      REG_COUNT:    rdata = w_count_rd;
      REG_COMPARE:  rdata = w_compare_rd;
      REG_STATUS:   rdata = w_byp ? w_status_wr : w_status_q;
      REG_CAUSE:    rdata = w_byp ? w_cause_wr : w_cause_q;
      REG_EPC:      rdata = w_byp ? wdata : r_epc;
      default:      rdata = '0;
    endcase
  end

  assign epc     = r_epc;
  assign int_req = r_ie & ~r_exl & (|({r_ip_hw, r_ip_sw} & r_im));

endmodule

// File: tb/tb_cp0_regs.sv
// Bench for cp0_regs: directed vector table, reset/timer sequences, then random traffic vs a register-level model.
module tb_cp0_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [5:0]  hw_int;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [31:0] epc;
  logic        int_req;

  int n_tests = 0;
  int n_fail  = 0;

  cp0_regs dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata), .hw_int(hw_int), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr), .eret(eret),
    .epc(epc), .int_req(int_req)
  );

  always #5 clk = ~clk;

`ifdef CP0_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [5:0]  hw;
    logic        ev;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        bd;
    logic [31:0] badv;
    logic        er;
    logic [31:0] x_rdata;
    logic [31:0] x_epc;
    logic        x_int;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] ra, input logic [5:0] hw, input logic ev,
                              input logic [4:0] code, input logic [31:0] pc, input logic bd,
                              input logic [31:0] bv, input logic er, input logic [31:0] xr,
                              input logic [31:0] xe, input logic xi);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd; v.raddr = ra; v.hw = hw; v.ev = ev; v.code = code;
    v.pc = pc; v.bd = bd; v.badv = bv; v.er = er; v.x_rdata = xr; v.x_epc = xe; v.x_int = xi;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0; raddr = '0; hw_int = '0; exc_valid = 1'b0;
    exc_code = '0; exc_pc = '0; exc_bd = 1'b0; exc_badvaddr = '0; eret = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    we = v.we; waddr = v.waddr; wdata = v.wdata; raddr = v.raddr; hw_int = v.hw;
    exc_valid = v.ev; exc_code = v.code; exc_pc = v.pc; exc_bd = v.bd;
    exc_badvaddr = v.badv; eret = v.er;
  endtask

  // Architectural model: whole-register values, Cause.TI kept apart in m_ti.
  logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
  logic        m_toggle, m_ti;

  task automatic m_reset();
    m_status = 32'h0040_0000; m_cause = '0; m_epc = '0; m_badv = '0;
    m_count = '0; m_compare = '0; m_toggle = 1'b0; m_ti = 1'b0;
  endtask

  function automatic logic [31:0] m_read();
    logic        byp;
    logic [31:0] cause_rd;
    byp      = we && (waddr == raddr);
    cause_rd = m_cause | ({31'b0, m_ti} << 30);
    case (raddr)
      5'd8:    return m_badv;
      5'd9:    return TIMER ? (byp ? wdata : m_count) : 32'h0;
      5'd11:   return TIMER ? (byp ? wdata : m_compare) : 32'h0;
      5'd12:   return byp ? ((wdata & 32'h0000_FF03) | 32'h0040_0000) : m_status;
      5'd13:   return byp ? ((cause_rd & ~32'h0000_0300) | (wdata & 32'h0000_0300)) : cause_rd;
      5'd14:   return byp ? wdata : m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_int();
    return m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'h0);
  endfunction

  task automatic m_clock();
    logic [31:0] ns, nc, ne, nb, nct, ncp;
    logic        ntg, nti;
    ns = m_status; nc = m_cause; ne = m_epc; nb = m_badv;
    nct = m_count; ncp = m_compare; ntg = m_toggle; nti = m_ti;
    nc[15:10] = {hw_int[5] | m_ti, hw_int[4:0]};
    if (we && waddr == 5'd12) begin
      ns[15:8] = wdata[15:8];
      ns[0]    = wdata[0];
      if (!exc_valid && !eret) ns[1] = wdata[1];
    end
    if (we && waddr == 5'd13) nc[9:8] = wdata[9:8];
    if (we && waddr == 5'd14 && !exc_valid) ne = wdata;
    if (exc_valid) begin
      nc[6:2] = exc_code;
      if (!m_status[1]) begin
        ne     = exc_bd ? exc_pc - 32'd4 : exc_pc;
        nc[31] = exc_bd;
      end
      ns[1] = 1'b1;
      if (exc_code == 5'd4 || exc_code == 5'd5) nb = exc_badvaddr;
    end else if (eret) begin
      ns[1] = 1'b0;
    end
    if (TIMER) begin
      if (we && waddr == 5'd9) begin
        nct = wdata; ntg = 1'b0;
      end else begin
        ntg = !m_toggle;
        if (m_toggle) nct = m_count + 32'd1;
      end
      if (we && waddr == 5'd11) ncp = wdata;
      if (we && waddr == 5'd11) nti = 1'b0;
      else if (m_count == m_compare) nti = 1'b1;
    end
    m_status = ns; m_cause = nc; m_epc = ne; m_badv = nb;
    m_count = nct; m_compare = ncp; m_toggle = ntg; m_ti = nti;
  endtask

  function automatic logic [4:0] pick_addr();
    logic [4:0] regs[6];
    regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
    if ($urandom_range(0, 3) != 0) return regs[$urandom_range(0, 5)];
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    //                 we wa     wdata          ra     hw     ev code  pc             bd badv           er  rdata          epc            int
    vecs[0]  = mk(1, 5'd11, 32'hFFFF_0000, 5'd12, 6'd0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0040_0000, 32'h0,         0);
    vecs[1]  = mk(0, 5'd0,  32'h0,         5'd13, 6'd0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0000_0000, 32'h0,         0);
    vecs[2]  = mk(0, 5'd0,  32'h0,         5'd14, 6'd0, 1, 5'd4, 32'hBFC0_0100, 1, 32'h1234_5671, 0, 32'h0000_0000, 32'h0,         0);
    vecs[3]  = mk(0, 5'd0,  32'h0,         5'd14, 6'd0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'hBFC0_00FC, 32'hBFC0_00FC, 0);
    vecs[4]  = mk(0, 5'd0,  32'h0,         5'd13, 6'd0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h8000_0010, 32'hBFC0_00FC, 0);
    vecs[5]  = mk(0, 5'd0,  32'h0,         5'd8,  6'd0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h1234_5671, 32'hBFC0_00FC, 0);
    vecs[6]  = mk(0, 5'd0,  32'h0,         5'd12, 6'd0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0040_0002, 32'hBFC0_00FC, 0);
    vecs[7]  = mk(0, 5'd0,  32'h0,         5'd12, 6'd0, 1, 5'd0, 32'h8000_0000, 0, 32'hDEAD_BEEF, 0, 32'h0040_0002, 32'hBFC0_00FC, 0);
    vecs[8]  = mk(0, 5'd0,  32'h0,         5'd14, 6'd0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'hBFC0_00FC, 32'hBFC0_00FC, 0);
    vecs[9]  = mk(0, 5'd0,  32'h0,         5'd13, 6'd0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h8000_0000, 32'hBFC0_00FC, 0);
    vecs[10] = mk(0, 5'd0,  32'h0,         5'd8,  6'd0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h1234_5671, 32'hBFC0_00FC, 0);
    vecs[11] = mk(1, 5'd12, 32'h0000_0401, 5'd12, 6'd1, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0040_0401, 32'hBFC0_00FC, 0);
    vecs[12] = mk(0, 5'd0,  32'h0,         5'd13, 6'd1, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h8000_0400, 32'hBFC0_00FC, 1);
    vecs[13] = mk(1, 5'd12, 32'h0000_0403, 5'd12, 6'd1, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0040_0403, 32'hBFC0_00FC, 1);
    vecs[14] = mk(0, 5'd0,  32'h0,         5'd12, 6'd1, 0, 5'd0, 32'h0,         0, 32'h0,         1, 32'h0040_0403, 32'hBFC0_00FC, 0);
    vecs[15] = mk(0, 5'd0,  32'h0,         5'd12, 6'd1, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0040_0401, 32'hBFC0_00FC, 1);
    vecs[16] = mk(1, 5'd14, 32'h1111_1110, 5'd12, 6'd1, 1, 5'd8, 32'h8000_0180, 0, 32'h0,         1, 32'h0040_0401, 32'hBFC0_00FC, 1);
    vecs[17] = mk(0, 5'd0,  32'h0,         5'd14, 6'd1, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h8000_0180, 32'h8000_0180, 0);
    vecs[18] = mk(0, 5'd0,  32'h0,         5'd12, 6'd1, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0040_0403, 32'h8000_0180, 0);
    vecs[19] = mk(0, 5'd0,  32'h0,         5'd13, 6'd1, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0000_0420, 32'h8000_0180, 0);
    vecs[20] = mk(1, 5'd13, 32'hFFFF_FFFF, 5'd13, 6'd1, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0000_0720, 32'h8000_0180, 0);
    vecs[21] = mk(1, 5'd8,  32'hAAAA_AAAA, 5'd8,  6'd1, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h1234_5671, 32'h8000_0180, 0);
    vecs[22] = mk(1, 5'd3,  32'hFFFF_FFFF, 5'd3,  6'd1, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0000_0000, 32'h8000_0180, 0);
    vecs[23] = mk(0, 5'd0,  32'h0,         5'd13, 6'd0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0000_0720, 32'h8000_0180, 0);
    vecs[24] = mk(0, 5'd0,  32'h0,         5'd13, 6'd0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0000_0320, 32'h8000_0180, 0);

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].x_rdata);
      check($sformatf("vec%0d_epc", i), epc, vecs[i].x_epc);
      check($sformatf("vec%0d_int", i), {31'b0, int_req}, {31'b0, vecs[i].x_int});
      @(posedge clk);
      #1;
    end

    // Reset coinciding with exception, ERET and MTC0 discards all of them.
    idle();
    rst = 1'b1; exc_valid = 1'b1; eret = 1'b1; exc_code = 5'd4; exc_pc = 32'h8000_0200;
    exc_badvaddr = 32'h5555_5555; we = 1'b1; waddr = 5'd12; wdata = 32'h0000_FF03; hw_int = 6'h3F;
    @(posedge clk);
    #1 idle(); rst = 1'b0; raddr = 5'd13;
    @(negedge clk);
    check("rst_cause", rdata, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_int", {31'b0, int_req}, 32'h0);
    raddr = 5'd12;
    #1 check("rst_status", rdata, 32'h0040_0000);
    raddr = 5'd8;
    #1 check("rst_badvaddr", rdata, 32'h0);
    @(posedge clk);
    #1;

`ifdef CP0_TIMER_EN
    begin
      int  waited;
      bit  seen;
      seen = 1'b0;
      we = 1'b1; waddr = 5'd11; wdata = 32'd5;
      @(posedge clk);
      #1 waddr = 5'd9; wdata = 32'd0;
      @(posedge clk);
      #1 idle(); raddr = 5'd13;
      for (waited = 0; waited < 40 && !seen; waited++) begin
        @(negedge clk);
        if (rdata[30] && rdata[15]) seen = 1'b1;
        else @(posedge clk);
      end
      check("timer_ti_seen", {31'b0, seen}, 32'h1);
      check("timer_latency_ok", {31'b0, (waited >= 10 && waited <= 14)}, 32'h1);
      @(posedge clk);
      #1 we = 1'b1; waddr = 5'd11; wdata = 32'd100;
      @(posedge clk);
      #1 idle(); raddr = 5'd13;
      @(negedge clk);
      check("timer_ti_cleared", {31'b0, rdata[30]}, 32'h0);
      @(posedge clk);
      #1 we = 1'b1; waddr = 5'd9; wdata = 32'hFFFF_FFFF;
      @(posedge clk);
      #1 idle(); raddr = 5'd9;
      @(negedge clk);
      check("count_loaded", rdata, 32'hFFFF_FFFF);
      @(negedge clk);
      check("count_hold", rdata, 32'hFFFF_FFFF);
      @(negedge clk);
      check("count_wrap", rdata, 32'h0);
      @(posedge clk);
      #1;
    end
`endif

    // Random traffic against the model.
    idle();
    rst = 1'b1;
    @(posedge clk);
    m_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 299) == 0);
      we           = $urandom_range(0, 1);
      waddr        = pick_addr();
      wdata        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      raddr        = ($urandom_range(0, 3) == 0) ? waddr : pick_addr();
      if ($urandom_range(0, 3) == 0) hw_int = 6'($urandom);
      exc_valid    = ($urandom_range(0, 15) == 0);
      exc_code     = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(4, 5)) : 5'($urandom);
      exc_pc       = $urandom & 32'hFFFF_FFFC;
      exc_bd       = $urandom_range(0, 1);
      exc_badvaddr = $urandom;
      eret         = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      check($sformatf("rnd%0d_rdata", i), rdata, m_read());
      check($sformatf("rnd%0d_epc", i), epc, m_epc);
      check($sformatf("rnd%0d_int", i), {31'b0, int_req}, {31'b0, m_int()});
      @(posedge clk);
      if (rst) m_reset();
      else     m_clock();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
